// File: rtl/div_unit_pkg.sv
// Shared definitions for the multi-cycle divide engine.
package div_unit_pkg;

  localparam int unsigned DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_BUSY = 2'b01,
    DIV_DONE = 2'b10
  } div_state_e;

endpackage

// File: rtl/div_unit_signfix.sv
// Conditional two's complement negation, used for operand magnitudes and result sign fix.
module div_unit_signfix
  import div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] val,
  input  logic             neg,
  output logic [WIDTH-1:0] res_c
);

  // Negate when requested, otherwise pass through; result truncates to WIDTH.
  always_comb begin
    res_c = val;
    if (neg) res_c = WIDTH'(~val + WIDTH'(1));
  end

endmodule

// File: rtl/div_unit.sv
// Fixed-latency restoring divider for MIPS DIV/DIVU; quotient on lo_o, remainder on hi_o.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             annul,
  output logic             done,
  output logic             busy,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  div_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic             qneg_q;
  logic             rneg_q;
  logic             dbz_q;

  logic [WIDTH-1:0] a_mag_c;
  logic [WIDTH-1:0] b_mag_c;
  logic [WIDTH:0]   rem_sh_c;
  logic [WIDTH-1:0] diff_c;
  logic             trial_ok_c;
  logic [WIDTH-1:0] rem_nx_c;
  logic [WIDTH-1:0] quo_nx_c;
  logic [WIDTH-1:0] rem_fix_c;
  logic [WIDTH-1:0] quo_fix_c;

  // Operand magnitudes; unsigned mode passes the raw values through.
  div_unit_signfix #(.WIDTH(WIDTH)) u_abs_a (
    .val   (a_i),
    .neg   (signed_i & a_i[WIDTH-1]),
    .res_c (a_mag_c)
  );

  div_unit_signfix #(.WIDTH(WIDTH)) u_abs_b (
    .val   (b_i),
    .neg   (signed_i & b_i[WIDTH-1]),
    .res_c (b_mag_c)
  );

  // One restoring step: shift remainder:quotient left, trial subtract, keep if non-negative.
  always_comb begin
    rem_sh_c   = {rem_q, quo_q[WIDTH-1]};
    trial_ok_c = (rem_sh_c >= {1'b0, dvs_q});
    diff_c     = WIDTH'(rem_sh_c - {1'b0, dvs_q});
    rem_nx_c   = trial_ok_c ? diff_c : rem_sh_c[WIDTH-1:0];
    quo_nx_c   = {quo_q[WIDTH-2:0], trial_ok_c};
  end

  // Sign fix of the final step's results.
  div_unit_signfix #(.WIDTH(WIDTH)) u_fix_q (
    .val   (quo_nx_c),
    .neg   (qneg_q),
    .res_c (quo_fix_c)
  );

  div_unit_signfix #(.WIDTH(WIDTH)) u_fix_r (
    .val   (rem_nx_c),
    .neg   (rneg_q),
    .res_c (rem_fix_c)
  );

  // Control FSM, iteration datapath and registered results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= DIV_IDLE;
      cnt    <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
      hi_o   <= '0;
      lo_o   <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: begin
          done <= 1'b0;
          if (start && !annul) begin
            state  <= DIV_BUSY;
            busy   <= 1'b1;
            cnt    <= '0;
            rem_q  <= '0;
            quo_q  <= a_mag_c;
            dvs_q  <= b_mag_c;
            qneg_q <= signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
            rneg_q <= signed_i & a_i[WIDTH-1];
            dbz_q  <= (b_i == '0);
          end else begin
            busy <= 1'b0;
          end
        end
        DIV_BUSY: begin
          if (annul) begin
            state <= DIV_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end else begin
            rem_q <= rem_nx_c;
            quo_q <= quo_nx_c;
            cnt   <= cnt + CNT_W'(1);
            if (cnt == LAST_STEP) begin
              state <= DIV_DONE;
              done  <= 1'b1;
              hi_o  <= rem_fix_c;
              lo_o  <= dbz_q ? '1 : quo_fix_c;
            end else begin
              done <= 1'b0;
            end
          end
        end
        DIV_DONE: begin
          state <= DIV_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= DIV_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed table, random vs reference model, corner sequences.
module tb_div_unit;

  localparam int unsigned W   = 32;
  localparam int          LAT = 33;

  logic         clk;
  logic         rst;
  logic         start;
  logic         signed_i;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         annul;
  logic         done;
  logic         busy;
  logic [W-1:0] hi_o;
  logic [W-1:0] lo_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] last_lo;
  logic [W-1:0] last_hi;

  typedef struct {
    bit           s;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
  } vec_t;

  vec_t vecs[10];

  div_unit dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .signed_i (signed_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .annul    (annul),
    .done     (done),
    .busy     (busy),
    .hi_o     (hi_o),
    .lo_o     (lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  // Reference: plain integer division with MIPS-style special cases.
  task automatic ref_div(input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] lo, output logic [W-1:0] hi);
    if (b == 0) begin
      lo = '1;
      hi = a;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      lo = 32'h8000_0000;
      hi = 0;
    end else if (s) begin
      lo = $signed(a) / $signed(b);
      hi = $signed(a) % $signed(b);
    end else begin
      lo = a / b;
      hi = a % b;
    end
  endtask

  // Called at a negedge with inputs already driven; returns cycles from launch to done.
  task automatic wait_done(output int lat, output bit busy_ok);
    lat = 0;
    busy_ok = 1'b1;
    for (int k = 1; k <= LAT + 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (!busy) busy_ok = 1'b0;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  // Full single divide with start held until done, then released.
  task automatic run_one(input string tag, input bit s, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp_lo,
                         input logic [W-1:0] exp_hi);
    int lat;
    bit bok;
    start = 1'b1; signed_i = s; a_i = a; b_i = b;
    wait_done(lat, bok);
    start = 1'b0;
    chk({tag, ".latency"}, W'(lat), W'(LAT));
    chk({tag, ".busy_during"}, W'(bok), W'(1));
    chk({tag, ".lo"}, lo_o, exp_lo);
    chk({tag, ".hi"}, hi_o, exp_hi);
    last_lo = exp_lo;
    last_hi = exp_hi;
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".done_after"}, W'(done), W'(0));
    chk({tag, ".busy_after"}, W'(busy), W'(0));
  endtask

  initial begin
    logic [W-1:0] e_lo, e_hi;
    int lat;
    bit bok;

    vecs[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
    vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF};
    vecs[2] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0};
    vecs[3] = '{1'b0, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678};
    vecs[4] = '{1'b1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB};
    vecs[5] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0};
    vecs[6] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1};
    vecs[7] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000};
    vecs[8] = '{1'b1, 32'hFFFF_FFF8,  32'hFFFF_FFFD,  32'd2,          32'hFFFF_FFFE};
    vecs[9] = '{1'b0, 32'd5,          32'd9,          32'd0,          32'd5};

    rst = 1'b1; start = 1'b0; signed_i = 1'b0; a_i = '0; b_i = '0; annul = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset.done", W'(done), W'(0));
    chk("reset.busy", W'(busy), W'(0));
    chk("reset.hi", hi_o, '0);
    chk("reset.lo", lo_o, '0);
    rst = 1'b0;
    @(negedge clk);

    // Directed table.
    for (int i = 0; i < 10; i++) begin
      run_one($sformatf("vec%0d", i), vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].lo, vecs[i].hi);
    end

    // Randomized against the reference model.
    for (int i = 0; i < 40; i++) begin
      bit s;
      logic [W-1:0] a, b;
      int sel;
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      sel = $urandom_range(0, 4);
      if (sel == 0) b = '0;
      else if (sel == 1) b = W'($urandom_range(1, 15));
      else if (sel == 2) b = -W'($urandom_range(1, 15));
      else b = $urandom;
      ref_div(s, a, b, e_lo, e_hi);
      run_one($sformatf("rnd%0d", i), s, a, b, e_lo, e_hi);
    end

    // Annul mid-divide: abort, results unchanged, then relaunch.
    start = 1'b1; signed_i = 1'b0; a_i = 32'd1000; b_i = 32'd3;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
    annul = 1'b1; start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("annul.busy", W'(busy), W'(0));
    chk("annul.done", W'(done), W'(0));
    chk("annul.hi_kept", hi_o, last_hi);
    chk("annul.lo_kept", lo_o, last_lo);
    annul = 1'b0;
    start = 1'b1; a_i = 32'd15; b_i = 32'd4;
    wait_done(lat, bok);
    start = 1'b0;
    chk("annul.relaunch_latency", W'(lat), W'(LAT));
    chk("annul.relaunch_lo", lo_o, 32'd3);
    chk("annul.relaunch_hi", hi_o, 32'd3);
    @(negedge clk);

    // Annul beats start in IDLE.
    start = 1'b1; annul = 1'b1; a_i = 32'd77; b_i = 32'd7;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("annul_idle.busy", W'(busy), W'(0));
    start = 1'b0; annul = 1'b0;
    @(negedge clk);

    // Back-to-back with start continuously high.
    start = 1'b1; signed_i = 1'b0; a_i = 32'd9; b_i = 32'd3;
    wait_done(lat, bok);
    chk("b2b.first_latency", W'(lat), W'(LAT));
    chk("b2b.first_lo", lo_o, 32'd3);
    chk("b2b.first_hi", hi_o, 32'd0);
    a_i = 32'd10; b_i = 32'd4;
    @(posedge clk);
    @(negedge clk);
    chk("b2b.idle_gap_busy", W'(busy), W'(0));
    chk("b2b.idle_gap_done", W'(done), W'(0));
    wait_done(lat, bok);
    start = 1'b0;
    chk("b2b.second_latency", W'(lat), W'(LAT));
    chk("b2b.second_lo", lo_o, 32'd2);
    chk("b2b.second_hi", hi_o, 32'd2);
    @(negedge clk);

    // Reset in the middle of a divide.
    start = 1'b1; signed_i = 1'b1; a_i = 32'd50; b_i = 32'd5;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1; start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst.done", W'(done), W'(0));
    chk("midrst.busy", W'(busy), W'(0));
    chk("midrst.hi", hi_o, '0);
    chk("midrst.lo", lo_o, '0);
    rst = 1'b0;
    @(negedge clk);
    run_one("post_rst", 1'b0, 32'd15, 32'd4, 32'd3, 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
